// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches consecutive words ahead of the core PC
// and serves them one per cycle, with flush-and-refetch on a PC redirect.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_ren,
  input  logic [31:0]            inst_addr,
  output logic [31:0]            inst_data,
  output logic                   inst_valid,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] head_ptr_r;
  logic [AW-1:0] tail_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic [31:0]   head_addr_r;
  logic [31:0]   head_addr_s;
  logic [31:0]   fetch_addr_r;
  logic [31:0]   fetch_addr_s;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_addr_s;
  state_t        state_r;
  state_t        state_s;

  logic [31:0]   target_s;
  logic          match_s;
  logic          hit_s;
  logic          redirect_s;
  logic          wr_s;

  // head_addr is always word-aligned, so a full compare against the aligned PC suffices
  assign target_s   = inst_addr & 32'hFFFF_FFFC;
  assign match_s    = (target_s == head_addr_r);
  assign hit_s      = inst_ren & match_s & (count_r != {CW{1'b0}});
  assign redirect_s = inst_ren & ~match_s;
  // ack data is kept only for a live request that is not being flushed this cycle
  assign wr_s       = (state_r == REQ) & mem_ack & ~redirect_s;

  assign inst_valid = hit_s;
  assign inst_data  = hit_s ? mem_r[head_ptr_r] : 32'h0000_0000;
  assign mem_req    = (state_r != IDLE);
  assign mem_addr   = mem_addr_r;
  assign occupancy  = count_r;

  // Next-state, occupancy and address bookkeeping
  always_comb begin
    count_s      = count_r;
    head_addr_s  = head_addr_r;
    fetch_addr_s = fetch_addr_r;
    state_s      = state_r;
    mem_addr_s   = mem_addr_r;

    if (redirect_s) begin
      count_s      = {CW{1'b0}};
      head_addr_s  = target_s;
      fetch_addr_s = target_s;
    end else begin
      count_s      = count_r + {{(CW-1){1'b0}}, wr_s} - {{(CW-1){1'b0}}, hit_s};
      head_addr_s  = hit_s ? (head_addr_r + 32'd4) : head_addr_r;
      fetch_addr_s = wr_s ? (fetch_addr_r + 32'd4) : fetch_addr_r;
    end

    case (state_r)
      IDLE: begin
        if (count_s < DEPTH_C) state_s = REQ;
        else                   state_s = IDLE;
      end
      REQ: begin
        if (mem_ack)         state_s = (count_s < DEPTH_C) ? REQ : IDLE;
        else if (redirect_s) state_s = DRAIN;
        else                 state_s = REQ;
      end
      DRAIN: begin
        if (mem_ack) state_s = (count_s < DEPTH_C) ? REQ : IDLE;
        else         state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase

    // a stalled REQ has fetch_addr == mem_addr, so reloading is harmless there
    if (state_s == REQ) mem_addr_s = fetch_addr_s;
    else                mem_addr_s = mem_addr_r;
  end

  // Control state, pointers and addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      count_r      <= {CW{1'b0}};
      head_ptr_r   <= {AW{1'b0}};
      tail_ptr_r   <= {AW{1'b0}};
      head_addr_r  <= RESET_PC;
      fetch_addr_r <= RESET_PC;
      mem_addr_r   <= RESET_PC;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      head_addr_r  <= head_addr_s;
      fetch_addr_r <= fetch_addr_s;
      mem_addr_r   <= mem_addr_s;
      if (redirect_s) begin
        head_ptr_r <= {AW{1'b0}};
        tail_ptr_r <= {AW{1'b0}};
      end else begin
        head_ptr_r <= hit_s ? (head_ptr_r + AW'(1'b1)) : head_ptr_r;
        tail_ptr_r <= wr_s ? (tail_ptr_r + AW'(1'b1)) : tail_ptr_r;
      end
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[tail_ptr_r] <= mem_rdata;
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic          clk;
  logic          rst;
  logic          inst_ren;
  logic [31:0]   inst_addr;
  logic [31:0]   inst_data;
  logic          inst_valid;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] occupancy;

  logic          w_ren;
  logic [31:0]   w_addr;
  logic [31:0]   w_inst_data;
  logic          w_inst_valid;
  logic          w_mem_req;
  logic [31:0]   w_mem_addr;
  logic          w_mem_ack;
  logic [31:0]   w_mem_rdata;
  logic [CW-1:0] w_occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_head;
  logic [31:0] m_fetch;
  logic [31:0] m_req_addr;
  logic        m_pending;
  logic        m_stale;

  logic        last_hit;
  logic [31:0] last_data;
  logic [31:0] pc;
  logic [31:0] wrap_exp [4];

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst), .inst_ren(inst_ren), .inst_addr(inst_addr),
    .inst_data(inst_data), .inst_valid(inst_valid), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .occupancy(occupancy)
  );

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .inst_ren(w_ren), .inst_addr(w_addr),
    .inst_data(w_inst_data), .inst_valid(w_inst_valid), .mem_req(w_mem_req),
    .mem_addr(w_mem_addr), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
    .occupancy(w_occupancy)
  );

  assign w_mem_rdata = w_mem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_head     = RESET_PC;
    m_fetch    = RESET_PC;
    m_req_addr = RESET_PC;
    m_pending  = 1'b0;
    m_stale    = 1'b0;
  endtask

  // one clock edge of the abstract behaviour
  task automatic model_edge(input logic ren, input logic [31:0] addr, input logic ack);
    logic hit;
    logic redir;
    logic done;
    hit   = ren && (m_q.size() > 0) && (addr[31:2] == m_head[31:2]);
    redir = ren && (addr[31:2] != m_head[31:2]);
    done  = m_pending && ack;
    if (done && !m_stale && !redir) begin
      m_q.push_back(m_req_addr ^ KEY);
      m_fetch = m_fetch + 32'd4;
    end
    if (done) m_pending = 1'b0;
    if (hit) begin
      void'(m_q.pop_front());
      m_head = m_head + 32'd4;
    end
    if (redir) begin
      m_q.delete();
      m_head  = {addr[31:2], 2'b00};
      m_fetch = m_head;
      if (m_pending) m_stale = 1'b1;
    end
    if (!m_pending && (m_q.size() < DEPTH)) begin
      m_pending  = 1'b1;
      m_stale    = 1'b0;
      m_req_addr = m_fetch;
    end
  endtask

  // called at a negedge; drives one cycle, checks, advances model, returns at next negedge
  task automatic step(input logic ren, input logic [31:0] addr, input logic ack_en);
    logic ack;
    logic exp_hit;
    ack       = ack_en & m_pending;
    inst_ren  = ren;
    inst_addr = addr;
    mem_ack   = ack;
    mem_rdata = ack ? (m_req_addr ^ KEY) : 32'h0000_0000;
    #1;
    exp_hit = ren && (m_q.size() > 0) && (addr[31:2] == m_head[31:2]);
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_hit));
    check_eq("inst_data", inst_data, exp_hit ? m_q[0] : 32'h0000_0000);
    check_eq("mem_req", 32'(mem_req), 32'(m_pending));
    if (m_pending) check_eq("mem_addr", mem_addr, m_req_addr);
    check_eq("occupancy", 32'(occupancy), 32'(m_q.size()));
    last_hit  = exp_hit;
    last_data = inst_data;
    model_edge(ren, addr, ack);
    @(negedge clk);
  endtask

  task automatic release_reset();
    inst_ren  = 1'b0;
    inst_addr = 32'h0000_0000;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_0000;
    #3 rst = 1'b0;
    model_reset();
    model_edge(1'b0, 32'h0000_0000, 1'b0);
    @(negedge clk);
    pc = RESET_PC;
    check_eq("post_rst_req", 32'(mem_req), 32'd1);
    check_eq("post_rst_addr", mem_addr, RESET_PC);
  endtask

  // asynchronous reset landing between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(mem_req), 32'd0);
    check_eq("async_rst_occ", 32'(occupancy), 32'd0);
    check_eq("async_rst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    release_reset();
  endtask

  task automatic wait_hit(input string tag, input logic [31:0] addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b1, addr, 1'b1);
      if (last_hit) begin
        found = 1'b1;
        check_eq(tag, last_data, addr ^ KEY);
      end
    end
    check_eq({tag, "_found"}, 32'(found), 32'd1);
    pc = found ? (addr + 32'd4) : addr;
  endtask

  // wrap-around instance: free-running fetch from 0xFFFF_FFF8
  initial begin
    w_ren       = 1'b0;
    w_addr      = 32'h0000_0000;
    w_mem_ack   = 1'b1;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;
    @(negedge rst);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_eq("wrap_req", 32'(w_mem_req), 32'd1);
      check_eq("wrap_addr", w_mem_addr, wrap_exp[k]);
    end
    @(negedge clk);
    #1;
    check_eq("wrap_idle_req", 32'(w_mem_req), 32'd0);
    check_eq("wrap_occ", 32'(w_occupancy), 32'(DEPTH));
    check_eq("wrap_valid", 32'(w_inst_valid) | w_inst_data, 32'd0);
  end

  initial begin
    int first_hit;
    int hits;
    logic ren;

    rst       = 1'b1;
    inst_ren  = 1'b1;
    inst_addr = RESET_PC;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_0000;
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_data", inst_data, 32'd0);
    release_reset();

    // streaming: memory acks every cycle, core walks 0,4,8,...
    first_hit = -1;
    hits      = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, pc, 1'b1);
      if (last_hit) begin
        hits++;
        if (first_hit < 0) first_hit = i;
        pc = pc + 32'd4;
      end
    end
    check_eq("first_hit_cycle", 32'(first_hit), 32'd1);
    check_eq("stream_hits", 32'(hits), 32'd11);

    // fill with core idle
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0000_0000, 1'b1);
    check_eq("fill_occ", 32'(occupancy), 32'(DEPTH));
    check_eq("fill_req", 32'(mem_req), 32'd0);

    // redirect from a full queue
    step(1'b1, 32'h0000_0100, 1'b0);
    check_eq("redir_occ", 32'(occupancy), 32'd0);
    check_eq("redir_req", 32'(mem_req), 32'd1);
    check_eq("redir_addr", mem_addr, 32'h0000_0100);
    wait_hit("redir_data", 32'h0000_0100);

    // redirect while 0x8 is outstanding, ack delayed
    do_reset();
    step(1'b1, 32'h0000_0000, 1'b1);
    step(1'b1, 32'h0000_0000, 1'b1);
    check_eq("drain_pre_addr", mem_addr, 32'h0000_0008);
    step(1'b1, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq("drain_req", 32'(mem_req), 32'd1);
      check_eq("drain_addr", mem_addr, 32'h0000_0008);
      step(1'b1, 32'h0000_0040, 1'b0);
    end
    check_eq("drain_addr_ack", mem_addr, 32'h0000_0008);
    step(1'b1, 32'h0000_0040, 1'b1);
    check_eq("post_drain_addr", mem_addr, 32'h0000_0040);
    wait_hit("drain_data", 32'h0000_0040);

    // redirect coincident with an ack
    step(1'b1, 32'h0000_0200, 1'b1);
    check_eq("coinc_req", 32'(mem_req), 32'd1);
    check_eq("coinc_addr", mem_addr, 32'h0000_0200);
    wait_hit("coinc_data", 32'h0000_0200);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       pc = $urandom & 32'hFFFF_FFFC;
          1:       pc = 32'hFFFF_FFF0;
          default: pc = 32'($urandom_range(0, 63)) * 32'd4;
        endcase
      end
      ren = ($urandom_range(0, 3) != 0);
      step(ren, pc | 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (last_hit) pc = pc + 32'd4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port inst_ren, input, 1 bit: the core requests the instruction at inst_addr this cycle.
REQ-006 The block SHALL have port inst_addr, input, 32 bits: the core PC; bits [1:0] are ignored.
REQ-007 The block SHALL have port inst_data, output, 32 bits: the instruction word for inst_addr, meaningful only when inst_valid=1.
REQ-008 The block SHALL have port inst_valid, output, 1 bit: a hit this cycle; the core stalls IF while it is 0.
REQ-009 The block SHALL have port mem_req, output, 1 bit: the instruction-memory read request.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: the word-aligned read address, stable while mem_req=1.
REQ-011 The block SHALL have port mem_ack, input, 1 bit: the memory returns mem_rdata and completes the request this cycle.
REQ-012 The block SHALL have port mem_rdata, input, 32 bits: read data, valid when mem_ack=1.
REQ-013 The block SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: the number of valid entries (debug).

Function
REQ-014 The queue SHALL hold consecutive words starting at head_addr; fetch_addr SHALL be the next word to request; both SHALL be word-aligned.
REQ-015 A hit (inst_ren=1, occupancy>0, inst_addr[31:2]==head_addr[31:2]) SHALL combinationally drive inst_valid=1 and inst_data=head entry; at the clock edge the head is popped and head_addr advances by 4.
REQ-016 When inst_valid=0, inst_data SHALL be 32'h0; when inst_ren=0, nothing SHALL be popped.
REQ-017 A wait (inst_ren=1, occupancy==0, inst_addr[31:2]==head_addr[31:2]) SHALL give inst_valid=0 and SHALL NOT flush.
REQ-018 A redirect (inst_ren=1, inst_addr[31:2]!=head_addr[31:2]) SHALL give inst_valid=0 and, at the edge, empty the queue and set head_addr=fetch_addr={inst_addr[31:2],2'b00}.
REQ-019 The FSM SHALL have states IDLE (no request), REQ (mem_req=1, ack is kept) and DRAIN (mem_req=1 on the stale address, ack data discarded).
REQ-020 IDLE->REQ SHALL occur when occupancy+outstanding<DEPTH, with mem_addr=fetch_addr; fetch_addr advances by 4 when the request is acknowledged.
REQ-021 REQ with mem_ack=1 SHALL write mem_rdata to the tail, then go to REQ (next address, back-to-back) if space remains after this write, else IDLE.
REQ-022 A redirect while in REQ without mem_ack SHALL move the FSM to DRAIN.
REQ-023 DRAIN SHALL hold mem_req and mem_addr until mem_ack, discard the data, then go to REQ at the new fetch_addr.
REQ-024 A redirect in the same cycle as mem_ack SHALL discard that data and go directly to REQ at the new address, with no DRAIN.
REQ-025 A simultaneous pop and ack-write SHALL leave occupancy unchanged.
REQ-026 A write when full SHALL be impossible by construction; occupancy SHALL never exceed DEPTH.
REQ-027 Address increments SHALL wrap mod 2^32 (32'hFFFF_FFFC+4 -> 32'h0).
REQ-028 Minimum miss latency SHALL be: data acknowledged in cycle N becomes a hit in cycle N+1; there is no bypass.

Reset
REQ-029 While rst=1: queue empty, occupancy=0, head_addr=fetch_addr=RESET_PC, FSM=IDLE, mem_req=0, inst_valid=0, inst_data=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; the memory side SHALL tolerate mem_req dropping without ack.
REQ-031 In the first cycle after rst deasserts, mem_req SHALL be 1 with mem_addr=RESET_PC.

Verification
REQ-032 Reset release, mem_ack every cycle with rdata=addr^32'hA5A5_A5A5, core PC 0,4,8,... with inst_ren=1 -> first inst_valid in the cycle after the first ack; then one hit per cycle with correct data.
REQ-033 Core holds inst_ren=0 with mem_ack always 1 -> exactly DEPTH requests (0x0..0xC for DEPTH=4), occupancy=4, mem_req=0.
REQ-034 Queue holding 0x0..0xC, core requests 0x100 -> inst_valid=0, occupancy=0 next cycle, mem_addr=0x100, next hit returns the 0x100 data.
REQ-035 Request at 0x8 outstanding (ack delayed 3 cycles), redirect to 0x40 -> DRAIN holds mem_addr=0x8 until ack, the 0x8 data is never delivered, then mem_addr=0x40.
REQ-036 Redirect coincident with mem_ack -> no DRAIN; the next mem_addr is the redirect target; the acked data is dropped.
REQ-037 RESET_PC=32'hFFFF_FFF8, sequential fetch -> mem_addr sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
